// File: rtl/conv_phase_center_loader_pkg.sv
// Shared types and register-word layout for the conv_phase center loader.
// Holds the default widths, the load_centers bit map, FSM states and the queued command record.
package conv_phase_pkg;

   localparam int CP_ADDR_W = 9;
   localparam int CP_DATA_W = 16;

   localparam int LOAD_BIT = 31;
   localparam int ADDR_LSB = 16;
   localparam int DATA_LSB = 0;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } cp_state_e;

   typedef struct packed {
      logic [CP_ADDR_W-1:0] addr;
      logic [CP_DATA_W-1:0] data;
   } center_cmd_t;

   function automatic center_cmd_t decode_cmd(input logic [31:0] word);
      center_cmd_t cmd;
      cmd.addr = word[ADDR_LSB +: CP_ADDR_W];
      cmd.data = word[DATA_LSB +: CP_DATA_W];
      return cmd;
   endfunction

endpackage

// File: rtl/conv_phase_center_loader_fifo.sv
// Synchronous FIFO of center_cmd_t with occupancy count; pushes while full and pops while
// empty are ignored. Zero-latency read of the head entry, updates on the clock edge.
module center_cmd_fifo
   import conv_phase_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  center_cmd_t       push_dat,
   input  logic              pop,
   output center_cmd_t       pop_dat,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   center_cmd_t        mem_q [DEPTH];
   center_cmd_t        mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               push_en;
   logic               pop_en;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign pop_dat = mem_q[rd_ptr_q];

   assign push_en = push & ~full;
   assign pop_en  = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_en) begin
         mem_d[wr_ptr_q] = push_dat;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_en) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_en, pop_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the pointers alone define validity.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/conv_phase_center_loader.sv
// Queues load_centers commands and writes them to the center RAM only in the guard window after sync_in.
// Latency: load edge to ram_we = next sync_in + 2 cycles. Optional readback port under CENTER_READBACK_EN.
module conv_phase_center_loader
   import conv_phase_pkg::*;
#(
   parameter  int ADDR_W       = CP_ADDR_W,
   parameter  int DATA_W       = CP_DATA_W,
   parameter  int FIFO_DEPTH   = 4,
   parameter  int GUARD_CYCLES = 8,
   localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              user_clk,
   input  logic              user_rst_n,
   input  logic [31:0]       reg_word,
   input  logic              sync_in,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic [CNT_W-1:0]  pending,
   output logic              busy,
   output logic              overflow,
   input  logic              clr_overflow
`ifdef CENTER_READBACK_EN
   ,
   output logic [31:0]       readback
`endif
);

   cp_state_e          state_q, state_d;
   logic [7:0]         guard_q, guard_d;
   logic               load_hist_q, load_hist_d;
   logic               overflow_q, overflow_d;
   logic               ram_we_q, ram_we_d;
   logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]  ram_data_q, ram_data_d;

   logic               cmd_det;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;
   logic [CNT_W-1:0]   cnt_after;
   center_cmd_t        push_cmd;
   center_cmd_t        pop_cmd;
   logic               unused_word_bits;

   assign unused_word_bits = ^reg_word[30:25];

   // Rising edge of the load bit; history resets high so a level held through reset is ignored.
   assign cmd_det     = reg_word[LOAD_BIT] & ~load_hist_q;
   assign load_hist_d = reg_word[LOAD_BIT];
   assign push_cmd    = decode_cmd(reg_word);
   assign fifo_push   = cmd_det & ~fifo_full;

   always_comb begin
      overflow_d = overflow_q;
      if (cmd_det && fifo_full) begin
         overflow_d = 1'b1;
      end else if (clr_overflow) begin
         overflow_d = 1'b0;
      end
   end

   center_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (user_clk),
      .rst_n    (user_rst_n),
      .push     (fifo_push),
      .push_dat (push_cmd),
      .pop      (fifo_pop),
      .pop_dat  (pop_cmd),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   assign cnt_after = fifo_count - CNT_W'(fifo_pop) + CNT_W'(fifo_push);

   always_ff @(posedge user_clk) begin
      if (!user_rst_n) begin
         state_q <= IDLE;
         guard_q <= '0;
      end else begin
         state_q <= state_d;
         guard_q <= guard_d;
      end
   end

   always_comb begin
      state_d = state_q;
      guard_d = guard_q;
      case (state_q)
         IDLE: begin
            if (sync_in && !fifo_empty) begin
               state_d = DRAIN;
               guard_d = 8'(GUARD_CYCLES - 1);
            end
         end
         DRAIN: begin
            if (guard_q != '0) begin
               guard_d = guard_q - 1'b1;
            end
            if (guard_q == '0 || cnt_after == '0) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fifo_pop = (state_q == DRAIN) && !fifo_empty;
   end

   always_comb begin
      ram_we_d   = fifo_pop;
      ram_addr_d = ram_addr_q;
      ram_data_d = ram_data_q;
      if (fifo_pop) begin
         ram_addr_d = ADDR_W'(pop_cmd.addr);
         ram_data_d = DATA_W'(pop_cmd.data);
      end
   end

   always_ff @(posedge user_clk) begin
      if (!user_rst_n) begin
         load_hist_q <= 1'b1;
         overflow_q  <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_data_q  <= '0;
      end else begin
         load_hist_q <= load_hist_d;
         overflow_q  <= overflow_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_data_q  <= ram_data_d;
      end
   end

   assign ram_we   = ram_we_q;
   assign ram_addr = ram_addr_q;
   assign ram_data = ram_data_q;
   assign pending  = fifo_count;
   assign overflow = overflow_q;
   assign busy     = (fifo_count != '0) || (state_q != IDLE);

`ifdef CENTER_READBACK_EN
   logic [8:0]  last_addr_q, last_addr_d;
   logic [15:0] last_data_q, last_data_d;

   // Captured alongside the RAM write so readback tracks the value on ram_addr/ram_data.
   always_comb begin
      last_addr_d = last_addr_q;
      last_data_d = last_data_q;
      if (ram_we_d) begin
         last_addr_d = 9'(ram_addr_d);
         last_data_d = 16'(ram_data_d);
      end
   end

   always_ff @(posedge user_clk) begin
      if (!user_rst_n) begin
         last_addr_q <= '0;
         last_data_q <= '0;
      end else begin
         last_addr_q <= last_addr_d;
         last_data_q <= last_data_d;
      end
   end

   assign readback = {overflow_q, 6'b0, last_addr_q, last_data_q};
`endif

endmodule

// File: doc/conv_phase_center_loader.md
Name: conv_phase_center_loader

Overview:
- Sequences software-issued channel-center updates into the conv_phase center table of the 512-channel channelizer.
- Takes the raw 32-bit word from the load_centers ppc2simulink register, already in the user_clk domain, and edge-detects its load bit.
- Queues each command in a small FIFO.
- Drains queued writes into the center RAM only inside a guard window after each frame sync, so a center never changes mid-frame.

Parameters:
- ADDR_W, 9, channel address width (512 channels).
- DATA_W, 16, center value width.
- FIFO_DEPTH, 4, pending-command queue depth (power of 2, ≥2).
- GUARD_CYCLES, 8, cycles after sync_in during which RAM writes are permitted (1..255).

Ports:
- user_clk  in  1  sole clock; all logic rising-edge.
- user_rst_n  in  1  synchronous active-low reset.
- reg_word  in  32  ppc2simulink user_data_out; [31]=load, [24:16]=addr, [15:0]=center.
- sync_in  in  1  one-cycle frame-start pulse from the channelizer datapath.
- ram_we  out  1  center RAM write enable.
- ram_addr  out  ADDR_W  center RAM write address.
- ram_data  out  DATA_W  center RAM write data.
- pending  out  clog2(FIFO_DEPTH)+1  commands queued, not yet written.
- busy  out  1  high when pending≠0 or state≠IDLE.
- overflow  out  1  sticky: a load arrived with the FIFO full.
- clr_overflow  in  1  clears overflow (priority below a same-cycle new overflow).

Behaviour:
- Reset (user_rst_n=0 at a user_clk edge):
  - ram_we=0, ram_addr=0, ram_data=0, pending=0, busy=0, overflow=0.
  - FIFO emptied; state=IDLE; load-edge history register set to 1, so a load already high at reset release is not a command.
  - Reset mid-drain discards all queued commands; a write whose ram_we was high that cycle is not repeated.
- Capture:
  - A command is detected when reg_word[31] is 1 and was 0 the previous cycle.
  - addr/center are taken from reg_word in that same cycle and pushed next edge.
  - Push when FIFO full: command dropped, overflow←1, FIFO unchanged.
  - Software reissues a command by clearing then setting bit 31; two edges therefore need at least 2 cycles.
- FSM:
  - IDLE: on sync_in with FIFO non-empty → DRAIN, guard counter←GUARD_CYCLES-1. Otherwise stay.
  - DRAIN: each cycle with FIFO non-empty pops one entry and drives ram_we=1 with that addr/data, registered, 1 cycle after the pop decision. Guard counter decrements each cycle. When the counter=0 or the FIFO is empty after the pop → IDLE.
  - Entries left when the window closes wait for the next sync_in.
  - sync_in while already in DRAIN is ignored; the window is not extended.
- Writes per window: at most GUARD_CYCLES.
- Capture latency: load edge to earliest ram_we = next sync_in + 2 cycles.
- Simultaneous push and pop in the same cycle: both occur; pending unchanged.
  - A push into an empty FIFO in the sync_in cycle is not seen by that window's first pop decision. It is written in the same window only if the window is still open.
- pending counts pushes minus pops. It updates in the cycle after the event and never wraps.
- clr_overflow and a new overflow in the same cycle: overflow stays 1.

Optional Feature:
- Macro: CENTER_READBACK_EN.
- Defined:
  - Adds output readback [31:0] = {overflow, 6'b0, last_addr[8:0], last_data[15:0]}.
  - last_addr/last_data update on every ram_we=1 cycle; reset value 0.
  - Intended for a simulink2ppc status register.
- Undefined:
  - readback port absent; no extra registers.

Decomposition:
- Package conv_phase_pkg holds:
  - ADDR_W/DATA_W defaults.
  - reg_word bit positions (LOAD_BIT=31, ADDR_LSB=16, DATA_LSB=0).
  - FSM state enum {IDLE, DRAIN}.
  - center_cmd_t struct {addr, data}.
- One sub-module: center_cmd_fifo, a synchronous FIFO of center_cmd_t with push/pop/full/empty/count and sync active-low reset.

Test Plan:
1. Single load: reg_word=0x8005_1234 set after 0x0, then sync_in → ram_we for exactly one cycle with ram_addr=0x005, ram_data=0x1234, 2 cycles after sync_in. pending goes 1→0.
2. No sync: 3 distinct loads, no sync_in for 100 cycles → ram_we never asserts, pending=3, busy=1.
3. Window limit: GUARD_CYCLES=2, 4 loads queued, sync_in → 2 writes in order. Next sync_in → remaining 2 writes, then busy=0.
4. Overflow: FIFO_DEPTH=4, 5 loads without sync → overflow=1, pending=4. The 5th command is never written. clr_overflow → 0.
5. Load level held: bit 31 held high for 50 cycles → exactly one command queued. Bit 31 high at reset release → no command.
6. Reset mid-drain: user_rst_n low during DRAIN with 3 pending → all outputs 0 next cycle. Later sync_in produces no writes.
